// File: rtl/io_decompressor_pkg.sv
// Shared types and constants for the run-length decompressor on the host-to-accelerator IO path.
package io_pkg;

  localparam int WORD_W      = 16;
  localparam int RUN_LEN_W   = 15;
  localparam int FILL_W      = 5;
  localparam int RUN_BIT_POS = 15;
  localparam int RUN_LEN_MSB = 14;

  localparam logic [15:0] CNN_BASE_DEF = 16'h0000;
  localparam logic [15:0] IMG_BASE_DEF = 16'h4000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_EXPAND,
    S_ACK,
    S_WAIT,
    S_FLUSH,
    S_START
  } state_t;

endpackage

// File: rtl/io_decompressor_bit_packer.sv
// Packs run bits LSB-first into 16-bit words; produces a word when full or on flush.
module bit_packer
  import io_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 expand_en,
  input  logic                 flush_en,
  input  logic                 run_bit,
  input  logic [RUN_LEN_W-1:0] run_len,
  output logic [FILL_W-1:0]    take,
  output logic                 word_valid,
  output logic [WORD_W-1:0]    word
);

  // fill holds 0..15 between cycles; the extra bit lets fill+take reach 16
  logic [FILL_W-1:0]   fill;
  logic [FILL_W-1:0]   space;
  logic [FILL_W-1:0]   fill_sum;
  logic [WORD_W-1:0]   pack;
  logic [WORD_W-1:0]   pack_next;
  logic [WORD_W-1:0]   mask;
  logic [2*WORD_W-1:0] mask_wide;
  logic                full;

  always_comb begin
    space = FILL_W'(WORD_W) - fill;
    if (run_len < RUN_LEN_W'(space)) take = run_len[FILL_W-1:0];
    else                             take = space;
    fill_sum   = fill + take;
    mask_wide  = ((32'd1 << take) - 32'd1) << fill;
    mask       = mask_wide[WORD_W-1:0];
    pack_next  = run_bit ? (pack | mask) : (pack & ~mask);
    full       = (fill_sum == FILL_W'(WORD_W));
    word_valid = (expand_en && full) || (flush_en && (fill != '0));
    word       = expand_en ? pack_next : pack;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill <= '0;
      pack <= '0;
    end else if (clear || flush_en || (expand_en && full)) begin
      fill <= '0;
      pack <= '0;
    end else if (expand_en) begin
      fill <= fill_sum;
      pack <= pack_next;
    end
  end

endmodule

// File: rtl/io_decompressor.sv
// Run-length decompressor FSM and host handshake; writes packed words to on-chip memory.
// Optional DECOMP_STATS_EN adds word_count/bit_count statistics outputs.
module io_decompressor
  import io_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] CNN_BASE = ADDR_W'(CNN_BASE_DEF),
  parameter logic [ADDR_W-1:0] IMG_BASE = ADDR_W'(IMG_BASE_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              interrupt,
  input  logic              load,
  input  logic              cnn,
  input  logic [WORD_W-1:0] data,
  output logic              done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              proc_start,
`ifdef DECOMP_STATS_EN
  output logic [15:0]       word_count,
  output logic [31:0]       bit_count,
`endif
  output logic              busy
);

  state_t               state, state_next;
  logic [ADDR_W-1:0]    addr;
  logic                 run_bit;
  logic [RUN_LEN_W-1:0] run_len;
  logic                 restart;
  logic                 start_stream;
  logic                 capture_en;
  logic                 expand_en;
  logic                 flush_en;
  logic [FILL_W-1:0]    take;
  logic                 word_valid;
  logic [WORD_W-1:0]    word;

  assign restart = interrupt && load;
  assign busy    = (state != S_IDLE);

  bit_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_stream),
    .expand_en  (expand_en),
    .flush_en   (flush_en),
    .run_bit    (run_bit),
    .run_len    (run_len),
    .take       (take),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // A load command during CAPTURE/EXPAND/ACK/WAIT abandons the stream without flushing
  always_comb begin
    state_next   = state;
    start_stream = 1'b0;
    capture_en   = 1'b0;
    expand_en    = 1'b0;
    flush_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (interrupt) begin
          if (load) start_stream = 1'b1;
          else      state_next   = S_FLUSH;
        end
      end
      S_CAPTURE: begin
        if (restart) begin
          start_stream = 1'b1;
        end else begin
          capture_en = 1'b1;
          state_next = (data[RUN_LEN_MSB:0] == '0) ? S_ACK : S_EXPAND;
        end
      end
      S_EXPAND: begin
        if (restart) begin
          start_stream = 1'b1;
        end else begin
          expand_en = 1'b1;
          if (run_len == RUN_LEN_W'(take)) state_next = S_ACK;
        end
      end
      S_ACK: begin
        if (restart) start_stream = 1'b1;
        else         state_next   = S_WAIT;
      end
      S_WAIT: begin
        if (interrupt) begin
          if (load) start_stream = 1'b1;
          else      state_next   = S_FLUSH;
        end else begin
          state_next = S_CAPTURE;
        end
      end
      S_FLUSH: begin
        flush_en   = 1'b1;
        state_next = S_START;
      end
      S_START: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (start_stream) state_next = S_CAPTURE;
  end

  // proc_start trails START by a cycle so it never overlaps the flush write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr       <= '0;
      run_bit    <= 1'b0;
      run_len    <= '0;
      done       <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      proc_start <= 1'b0;
    end else begin
      done       <= (state_next == S_ACK);
      proc_start <= (state == S_START);
      mem_we     <= word_valid;
      if (word_valid) begin
        mem_addr  <= addr;
        mem_wdata <= word;
        addr      <= addr + ADDR_W'(1);
      end
      if (start_stream) addr <= cnn ? CNN_BASE : IMG_BASE;
      if (capture_en) begin
        run_bit <= data[RUN_BIT_POS];
        run_len <= data[RUN_LEN_MSB:0];
      end else if (expand_en) begin
        run_len <= run_len - RUN_LEN_W'(take);
      end
    end
  end

`ifdef DECOMP_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_count <= '0;
      bit_count  <= '0;
    end else if (start_stream) begin
      word_count <= '0;
      bit_count  <= '0;
    end else begin
      if (capture_en && (word_count != '1)) word_count <= word_count + 16'd1;
      if (expand_en) begin
        if (bit_count > (32'hFFFF_FFFF - 32'(take))) bit_count <= '1;
        else                                          bit_count <= bit_count + 32'(take);
      end
    end
  end
`endif

endmodule

// File: tb/tb_io_decompressor.sv
// Directed self-checking bench for io_decompressor; second instance exercises address wrap.
module tb_io_decompressor;
  import io_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        interrupt = 1'b0;
  logic        load = 1'b0;
  logic        cnn = 1'b0;
  logic [15:0] data = 16'h0000;

  logic        done, mem_we, proc_start, busy;
  logic [15:0] mem_addr, mem_wdata;
  logic        d2_done, d2_mem_we, d2_proc_start, d2_busy;
  logic [15:0] d2_mem_addr, d2_mem_wdata;
`ifdef DECOMP_STATS_EN
  logic [15:0] word_count, d2_word_count;
  logic [31:0] bit_count, d2_bit_count;
`endif

  io_decompressor dut (
    .clk(clk), .rst(rst), .interrupt(interrupt), .load(load), .cnn(cnn), .data(data),
    .done(done), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .proc_start(proc_start),
`ifdef DECOMP_STATS_EN
    .word_count(word_count), .bit_count(bit_count),
`endif
    .busy(busy)
  );

  io_decompressor #(.CNN_BASE(16'hFFFF)) dut_wrap (
    .clk(clk), .rst(rst), .interrupt(interrupt), .load(load), .cnn(cnn), .data(data),
    .done(d2_done), .mem_we(d2_mem_we), .mem_addr(d2_mem_addr), .mem_wdata(d2_mem_wdata),
    .proc_start(d2_proc_start),
`ifdef DECOMP_STATS_EN
    .word_count(d2_word_count), .bit_count(d2_bit_count),
`endif
    .busy(d2_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] wr_log[$];
  int          wr_cyc[$];
  logic [31:0] wr2_log[$];
  int          done_cnt = 0;
  int          proc_cnt = 0;
  int          proc_cyc = 0;
  int          overlap_cnt = 0;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_log.push_back({mem_addr, mem_wdata});
      wr_cyc.push_back(cyc);
    end
    if (d2_mem_we) wr2_log.push_back({d2_mem_addr, d2_mem_wdata});
    if (done) done_cnt <= done_cnt + 1;
    if (proc_start) begin
      proc_cnt <= proc_cnt + 1;
      proc_cyc <= cyc;
    end
    if ((mem_we && proc_start) || (done && proc_start)) overlap_cnt <= overlap_cnt + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_stream(input logic c, input logic [15:0] d);
    data = d; cnn = c; load = 1'b1; interrupt = 1'b1;
    @(negedge clk);
    interrupt = 1'b0;
  endtask

  task automatic wait_done(output int at);
    int got = 0;
    at = -1;
    for (int i = 0; i < 64 && got == 0; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        at  = cyc;
      end
    end
    chk("done_seen", got, 1);
  endtask

  // Called at the negedge where done was seen (ACK); issues end-of-load during WAIT
  task automatic end_stream;
    @(negedge clk);
    interrupt = 1'b1; load = 1'b0;
    @(negedge clk);
    interrupt = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int wb, wb2, db, pb, t, t1, t2;

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_wdata", mem_wdata, 16'h0000);
    chk("rst_proc", proc_start, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);

    // reset asserted while a write is on the bus mid-expansion
    start_stream(1'b0, 16'h8040);
    repeat (2) @(negedge clk);
    chk("rm_we_before", mem_we, 1);
    chk("rm_addr_before", mem_addr, 16'h4000);
    #1 rst = 1'b0;
    #1;
    chk("rm_we", mem_we, 0);
    chk("rm_addr", mem_addr, 16'h0000);
    chk("rm_wdata", mem_wdata, 16'h0000);
    chk("rm_busy", busy, 0);
    chk("rm_done", done, 0);
    @(negedge clk);
    rst = 1'b1; load = 1'b0; data = 16'h0000;
    wb2 = wr_log.size();
    repeat (4) @(negedge clk);
    chk("rm_no_write", wr_log.size() - wb2, 0);
    chk("rm_idle", busy, 0);

    // single 16-ones word on the CNN stream
    wb = wr_log.size(); db = done_cnt; pb = proc_cnt;
    start_stream(1'b1, 16'h8010);
    wait_done(t);
    end_stream();
    chk("c1_nwr", wr_log.size() - wb, 1);
    chk("c1_wr", wr_log[wb], {16'h0000, 16'hFFFF});
    chk("c1_lat", wr_cyc[wb], t);
    chk("c1_done", done_cnt - db, 1);
    chk("c1_proc", proc_cnt - pb, 1);
    chk("c1_idle", busy, 0);

    // run split across a word boundary, remainder flushed
    wb = wr_log.size(); pb = proc_cnt;
    start_stream(1'b0, 16'h0005);
    wait_done(t);
    data = 16'h800F;
    wait_done(t);
    end_stream();
    chk("sp_nwr", wr_log.size() - wb, 2);
    chk("sp_wr0", wr_log[wb], {16'h4000, 16'hFFE0});
    chk("sp_wr1", wr_log[wb+1], {16'h4001, 16'h000F});
    chk("sp_proc", proc_cnt - pb, 1);
    chk("sp_order", proc_cyc, wr_cyc[wb+1] + 1);

    // zero-length run leaves fill untouched and skips EXPAND
    wb = wr_log.size();
    start_stream(1'b0, 16'h0003);
    wait_done(t1);
    data = 16'h8000;
    wait_done(t2);
    chk("z_gap", t2 - t1, 3);
    data = 16'h800D;
    wait_done(t);
    end_stream();
    chk("z_nwr", wr_log.size() - wb, 1);
    chk("z_wr", wr_log[wb], {16'h4000, 16'hFFF8});

    // 48-zero run: three back-to-back writes; wrap instance crosses FFFF
    wb = wr_log.size(); wb2 = wr2_log.size(); db = done_cnt;
    start_stream(1'b1, 16'h0030);
    wait_done(t);
    end_stream();
    chk("l_nwr", wr_log.size() - wb, 3);
    chk("l_wr0", wr_log[wb], {16'h0000, 16'h0000});
    chk("l_wr1", wr_log[wb+1], {16'h0001, 16'h0000});
    chk("l_wr2", wr_log[wb+2], {16'h0002, 16'h0000});
    chk("l_first_cyc", wr_cyc[wb], t - 2);
    chk("l_last_cyc", wr_cyc[wb+2], t);
    chk("l_done", done_cnt - db, 1);
    chk("w_nwr", wr2_log.size() - wb2, 3);
    chk("w_wr0", wr2_log[wb2], {16'hFFFF, 16'h0000});
    chk("w_wr1", wr2_log[wb2+1], {16'h0000, 16'h0000});

    // restart during ACK with cnn toggled: partial fill discarded, new base
    wb = wr_log.size();
    start_stream(1'b0, 16'h0005);
    wait_done(t);
    data = 16'h8010; cnn = 1'b1; load = 1'b1; interrupt = 1'b1;
    @(negedge clk);
    interrupt = 1'b0;
    wait_done(t);
    end_stream();
    chk("r_nwr", wr_log.size() - wb, 1);
    chk("r_wr", wr_log[wb], {16'h0000, 16'hFFFF});

    chk("no_overlap", overlap_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
